// File: rtl/tc_irq_timer_if.sv
// Bus connection between the CPU bridge (master) and the interrupt timer (slave).
// The irq line is carried here as the slave's output toward the CPU core.
interface tc_irq_timer_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/tc_irq_timer.sv
// Down-counting timer that raises the CPU interrupt line on expiry.
// Registers: CTRL {IM, MODE[1:0], EN}, PRESET, COUNT (read-only); one-shot or auto-reload.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | stopped; COUNT holds, waits for EN
//   S_LOAD | COUNT <= PRESET
//   S_CNT  | counting down while EN; expiry sets irq_flag
//   S_INT  | one-shot: clear EN, back to idle; auto-reload: clear flag, reload
module tc_irq_timer #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  tc_irq_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  state_e            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;

  logic en;
  logic auto_reload;
  logic im;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign im          = ctrl_q[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > DATA_W'(1)) begin
          count_d = count_q - DATA_W'(1);
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes come last so they override the hardware EN clear and flag set.
    if (bus.we) begin
      case (bus.addr)
        ADDR_CTRL: begin
          ctrl_d     = bus.wdata[3:0];
          irq_flag_d = 1'b0;
        end
        ADDR_PRESET: begin
          preset_d   = bus.wdata;
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = {{(DATA_W-4){1'b0}}, ctrl_q};
      ADDR_PRESET: bus.rdata = preset_q;
      ADDR_COUNT:  bus.rdata = count_q;
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = im & irq_flag_q;

endmodule
